// File: rtl/reg_space_req_arbiter.sv
// reg_space_req_arbiter: shares one register-bank read/write request port
// between NUM_REQ requesters. Round-robin arbitration, one transaction in
// flight, write beats read within the winning requester.
// Optional macro REG_ARB_TIMEOUT_EN: abort RD/WR after TIMEOUT_CYC cycles,
// returning an error on reads and a sticky error for writes.
module reg_space_req_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255,
    localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        m_rreq_vld,
    input  logic [NUM_REQ*ADDR_W-1:0] m_rreq_addr,
    output logic [NUM_REQ-1:0]        m_rreq_rdy,
    output logic [DATA_W-1:0]         m_rack_data,
    output logic                      m_rack_err,
    output logic [NUM_REQ-1:0]        m_rack_vld,
    input  logic [NUM_REQ-1:0]        m_rack_rdy,
    input  logic [NUM_REQ-1:0]        m_wreq_vld,
    input  logic [NUM_REQ*ADDR_W-1:0] m_wreq_addr,
    input  logic [NUM_REQ*DATA_W-1:0] m_wreq_data,
    output logic [NUM_REQ-1:0]        m_wreq_rdy,
    output logic [ADDR_W-1:0]         s_rreq_addr,
    output logic                      s_rreq_vld,
    input  logic                      s_rreq_rdy,
    input  logic [DATA_W-1:0]         s_rack_data,
    input  logic                      s_rack_vld,
    output logic                      s_rack_rdy,
    output logic [ADDR_W-1:0]         s_wreq_addr,
    output logic [DATA_W-1:0]         s_wreq_data,
    output logic                      s_wreq_vld,
    input  logic                      s_wreq_rdy,
    output logic                      busy,
    output logic [ID_W-1:0]           grant_id
);
    localparam int PW = ID_W + 1;
    localparam logic [PW-1:0] NUM_REQ_C = PW'(NUM_REQ);

    typedef enum logic [1:0] {IDLE, RD, RSP, WR} state_t;
    state_t state, nstate;

    logic [ID_W-1:0]   rr_ptr, grant_q, nxt_ptr;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;
    logic              win_found, win_wr, tmo;
    logic [ID_W-1:0]   win_id, idx;
    logic [PW-1:0]     sum;

    // s_rreq_rdy mirrors the ack handshake; completion is taken from s_rack_vld
    logic unused_ok;
    assign unused_ok = s_rreq_rdy;

    // round-robin scan from rr_ptr upward with wrap; first eligible wins
    always_comb begin
        win_found = 1'b0;
        win_wr    = 1'b0;
        win_id    = rr_ptr;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr} + PW'(k);
            if (sum >= NUM_REQ_C) sum = sum - NUM_REQ_C;
            idx = sum[ID_W-1:0];
            if (!win_found && (m_wreq_vld[idx] || m_rreq_vld[idx])) begin
                win_found = 1'b1;
                win_id    = idx;
                win_wr    = m_wreq_vld[idx];
            end
        end
    end

    assign nxt_ptr = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nstate;
    end

    // next-state and handshake outputs
    always_comb begin
        nstate     = state;
        m_wreq_rdy = '0;
        m_rreq_rdy = '0;
        m_rack_vld = '0;
        case (state)
            IDLE: if (win_found && !rst) begin
                if (win_wr) begin
                    m_wreq_rdy[win_id] = 1'b1;
                    nstate = WR;
                end else begin
                    m_rreq_rdy[win_id] = 1'b1;
                    nstate = RD;
                end
            end
            RD:  if (s_rack_vld || tmo) nstate = RSP;
            RSP: begin
                m_rack_vld[grant_q] = 1'b1;
                if (m_rack_rdy[grant_q]) nstate = IDLE;
            end
            WR:  if (s_wreq_rdy || tmo) nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    // capture request, read data, and advance the round-robin pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr  <= '0;
            grant_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: if (win_found) begin
                    grant_q <= win_id;
                    if (win_wr) begin
                        addr_q  <= m_wreq_addr[int'(win_id)*ADDR_W +: ADDR_W];
                        wdata_q <= m_wreq_data[int'(win_id)*DATA_W +: DATA_W];
                    end else begin
                        addr_q  <= m_rreq_addr[int'(win_id)*ADDR_W +: ADDR_W];
                    end
                end
                RD: begin
                    if (s_rack_vld) rdata_q <= s_rack_data;
                    else if (tmo)   rdata_q <= '0;
                end
                RSP: if (m_rack_rdy[grant_q]) rr_ptr <= nxt_ptr;
                WR:  if (s_wreq_rdy || tmo)   rr_ptr <= nxt_ptr;
                default: ;
            endcase
        end
    end

`ifdef REG_ARB_TIMEOUT_EN
    localparam int CW0   = $clog2(TIMEOUT_CYC + 1);
    localparam int CNT_W = (CW0 > 8) ? CW0 : 8;
    logic [CNT_W-1:0] wait_cnt;
    logic             wr_err_sticky, rsp_err_q;

    // tmo marks the TIMEOUT_CYC-th cycle spent waiting in RD/WR
    assign tmo = (state == RD || state == WR) && (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

    // wait counter and error flags; a timed-out write is reported on the next read response
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt      <= '0;
            wr_err_sticky <= 1'b0;
            rsp_err_q     <= 1'b0;
        end else begin
            if (state == RD || state == WR) wait_cnt <= wait_cnt + 1'b1;
            else                            wait_cnt <= '0;
            if (state == WR && !s_wreq_rdy && tmo) wr_err_sticky <= 1'b1;
            if (state == RD && (s_rack_vld || tmo)) begin
                rsp_err_q     <= (tmo && !s_rack_vld) || wr_err_sticky;
                wr_err_sticky <= 1'b0;
            end
        end
    end
    assign m_rack_err = (state == RSP) && rsp_err_q;
`else
    assign tmo        = 1'b0;
    assign m_rack_err = 1'b0;
`endif

    assign s_rreq_vld  = (state == RD);
    assign s_rack_rdy  = (state == RD);
    assign s_rreq_addr = addr_q;
    assign s_wreq_vld  = (state == WR);
    assign s_wreq_addr = addr_q;
    assign s_wreq_data = wdata_q;
    assign m_rack_data = rdata_q;
    assign busy        = (state != IDLE);
    assign grant_id    = grant_q;

endmodule

// File: tb/tb_reg_space_req_arbiter.sv
// Directed bench for reg_space_req_arbiter with a scoreboard of expected
// downstream writes and upstream read responses.
module tb_reg_space_req_arbiter;
    localparam int NR = 2, AW = 16, DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic [NR-1:0]  m_rreq_vld, m_rreq_rdy, m_rack_vld, m_rack_rdy;
    logic [NR-1:0]  m_wreq_vld, m_wreq_rdy;
    logic [NR*AW-1:0] m_rreq_addr, m_wreq_addr;
    logic [NR*DW-1:0] m_wreq_data;
    logic [DW-1:0]  m_rack_data, s_rack_data, s_wreq_data;
    logic           m_rack_err, s_rreq_vld, s_rreq_rdy, s_rack_vld, s_rack_rdy;
    logic [AW-1:0]  s_rreq_addr, s_wreq_addr;
    logic           s_wreq_vld, s_wreq_rdy, busy;
    logic           grant_id;

    reg_space_req_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(4)) dut (
        .clk(clk), .rst(rst),
        .m_rreq_vld(m_rreq_vld), .m_rreq_addr(m_rreq_addr), .m_rreq_rdy(m_rreq_rdy),
        .m_rack_data(m_rack_data), .m_rack_err(m_rack_err), .m_rack_vld(m_rack_vld),
        .m_rack_rdy(m_rack_rdy), .m_wreq_vld(m_wreq_vld), .m_wreq_addr(m_wreq_addr),
        .m_wreq_data(m_wreq_data), .m_wreq_rdy(m_wreq_rdy),
        .s_rreq_addr(s_rreq_addr), .s_rreq_vld(s_rreq_vld), .s_rreq_rdy(s_rreq_rdy),
        .s_rack_data(s_rack_data), .s_rack_vld(s_rack_vld), .s_rack_rdy(s_rack_rdy),
        .s_wreq_addr(s_wreq_addr), .s_wreq_data(s_wreq_data), .s_wreq_vld(s_wreq_vld),
        .s_wreq_rdy(s_wreq_rdy), .busy(busy), .grant_id(grant_id)
    );

    assign s_rreq_rdy = s_rack_vld & s_rack_rdy;

    int checks = 0, failures = 0;
    logic [47:0] wq[$];   // {addr, data} of expected downstream writes
    logic [34:0] rq[$];   // {onehot id, err, data} of expected read responses
    logic [2:0]  gq[$];   // observed grants {is_write, rdy onehot}

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // scoreboard monitor: completed handshakes are compared at the falling edge
    always @(negedge clk) begin
        logic [47:0] we;
        logic [34:0] re;
        if (!rst && s_wreq_vld && s_wreq_rdy) begin
            if (wq.size() == 0) chk("wr_unexpected", 64'(s_wreq_addr), 64'hFFFF_FFFF);
            else begin
                we = wq.pop_front();
                chk("wr_addr", 64'(s_wreq_addr), 64'(we[47:32]));
                chk("wr_data", 64'(s_wreq_data), 64'(we[31:0]));
            end
        end
        if (!rst && m_rack_vld != 0 && rq.size() == 0)
            chk("rsp_unexpected", 64'(m_rack_vld), 64'd0);
        if (!rst && (m_rack_vld & m_rack_rdy) != 0 && rq.size() != 0) begin
            re = rq.pop_front();
            chk("rsp_id",   64'(m_rack_vld),  64'(re[34:33]));
            chk("rsp_err",  64'(m_rack_err),  64'(re[32]));
            chk("rsp_data", 64'(m_rack_data), 64'(re[31:0]));
        end
        if (m_wreq_rdy != 0) gq.push_back({1'b1, m_wreq_rdy});
        if (m_rreq_rdy != 0) gq.push_back({1'b0, m_rreq_rdy});
    end

    initial begin
        rst = 1'b1;
        m_rreq_vld = '0; m_rreq_addr = '0; m_rack_rdy = '0;
        m_wreq_vld = '0; m_wreq_addr = '0; m_wreq_data = '0;
        s_rack_data = '0; s_rack_vld = 1'b0; s_wreq_rdy = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("rst_busy", 64'(busy), 0);
        chk("rst_grant", 64'(grant_id), 0);
        chk("rst_s_rreq_vld", 64'(s_rreq_vld), 0);
        chk("rst_s_wreq_vld", 64'(s_wreq_vld), 0);
        chk("rst_m_rack_vld", 64'(m_rack_vld), 0);
        chk("rst_m_rack_data", 64'(m_rack_data), 0);

        // single posted write from requester 0
        m_wreq_vld = 2'b01; m_wreq_addr[15:0] = 16'h0000; m_wreq_data[31:0] = 32'h28;
        s_wreq_rdy = 1'b1;
        wq.push_back({16'h0000, 32'h28});
        #1 chk("t1_wrdy", 64'(m_wreq_rdy), 2'b01);
        step(); m_wreq_vld = '0;
        chk("t1_s_wvld", 64'(s_wreq_vld), 1);
        chk("t1_busy", 64'(busy), 1);
        step();
        chk("t1_busy_done", 64'(busy), 0);
        chk("t1_s_wvld_done", 64'(s_wreq_vld), 0);

        // read from requester 1 with a stalled response
        m_rreq_vld = 2'b10; m_rreq_addr[31:16] = 16'h0001;
        rq.push_back({2'b10, 1'b0, 32'h8400_0000});
        #1 chk("t2_rrdy", 64'(m_rreq_rdy), 2'b10);
        step(); m_rreq_vld = '0;
        chk("t2_s_rvld", 64'(s_rreq_vld), 1);
        chk("t2_s_raddr", 64'(s_rreq_addr), 16'h0001);
        chk("t2_s_rack_rdy", 64'(s_rack_rdy), 1);
        s_rack_vld = 1'b1; s_rack_data = 32'h8400_0000;
        step(); s_rack_vld = 1'b0; s_rack_data = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            chk("t2_hold_vld", 64'(m_rack_vld), 2'b10);
            chk("t2_hold_data", 64'(m_rack_data), 32'h8400_0000);
            step();
        end
        m_rack_rdy = 2'b10;
        step(); m_rack_rdy = '0;
        chk("t2_done_vld", 64'(m_rack_vld), 0);
        chk("t2_done_busy", 64'(busy), 0);

        // both requesters write continuously: grants must alternate
        gq.delete();
        m_wreq_addr = {16'h0B00, 16'h0A00}; m_wreq_data = {32'h1111_0001, 32'h0000_0A0A};
        for (int i = 0; i < 2; i++) begin
            wq.push_back({16'h0A00, 32'h0000_0A0A});
            wq.push_back({16'h0B00, 32'h1111_0001});
        end
        m_wreq_vld = 2'b11;
        for (int i = 0; i < 7; i++) step();
        m_wreq_vld = '0;
        step();
        chk("t3_grants", 64'(gq.size()), 4);
        for (int i = 0; i < 4 && i < gq.size(); i++)
            chk("t3_grant_order", 64'(gq[i]), (i % 2 == 0) ? 64'b101 : 64'b110);

        // simultaneous read and write from requester 0: write first
        gq.delete();
        m_wreq_vld = 2'b01; m_wreq_addr[15:0] = 16'h0020; m_wreq_data[31:0] = 32'h55;
        m_rreq_vld = 2'b01; m_rreq_addr[15:0] = 16'h0030;
        wq.push_back({16'h0020, 32'h55});
        #1 chk("t4_wrdy", 64'(m_wreq_rdy), 2'b01);
        chk("t4_rrdy_held", 64'(m_rreq_rdy), 0);
        step(); m_wreq_vld = '0;
        step();
        rq.push_back({2'b01, 1'b0, 32'hA5A5_0001});
        #1 chk("t4_rrdy", 64'(m_rreq_rdy), 2'b01);
        step(); m_rreq_vld = '0;
        chk("t4_s_raddr", 64'(s_rreq_addr), 16'h0030);
        s_rack_vld = 1'b1; s_rack_data = 32'hA5A5_0001; m_rack_rdy = 2'b01;
        step(); s_rack_vld = 1'b0;
        chk("t4_rsp_vld", 64'(m_rack_vld), 2'b01);
        step(); m_rack_rdy = '0;
        chk("t4_busy_done", 64'(busy), 0);
        chk("t4_grant_seq", 64'({gq.size() == 2 ? gq[0] : 3'b0, gq.size() == 2 ? gq[1] : 3'b0}), 64'b101_001);

        // reset in the middle of a read aborts it and clears the pointer
        m_rreq_vld = 2'b10; m_rreq_addr[31:16] = 16'h0005;
        step(); m_rreq_vld = '0;
        chk("t5_in_rd", 64'(s_rreq_vld), 1);
        rst = 1'b1;
        step(); rst = 1'b0;
        chk("t5_s_rvld", 64'(s_rreq_vld), 0);
        chk("t5_busy", 64'(busy), 0);
        chk("t5_m_rack_vld", 64'(m_rack_vld), 0);
        chk("t5_grant", 64'(grant_id), 0);
        m_wreq_vld = 2'b11; m_wreq_addr = {16'h00B0, 16'h00A0}; m_wreq_data = {32'hB, 32'hA};
        wq.push_back({16'h00A0, 32'hA});
        #1 chk("t5_ptr_zero", 64'(m_wreq_rdy), 2'b01);
        step(); m_wreq_vld = '0;
        step();

        // read of an address that never completes downstream
        m_rreq_vld = 2'b01; m_rreq_addr[15:0] = 16'h0010; m_rack_rdy = 2'b01;
`ifdef REG_ARB_TIMEOUT_EN
        rq.push_back({2'b01, 1'b1, 32'h0});
`endif
        step(); m_rreq_vld = '0;
        chk("t6_s_raddr", 64'(s_rreq_addr), 16'h0010);
`ifdef REG_ARB_TIMEOUT_EN
        for (int i = 0; i < 3; i++) step();
        chk("t6_still_rd", 64'(s_rreq_vld), 1);
        step();
        chk("t6_tmo_vld", 64'(m_rack_vld), 2'b01);
        chk("t6_tmo_err", 64'(m_rack_err), 1);
        step();
        chk("t6_tmo_idle", 64'(busy), 0);
`else
        for (int i = 0; i < 10; i++) step();
        chk("t6_busy_hang", 64'(busy), 1);
        chk("t6_s_rvld_hang", 64'(s_rreq_vld), 1);
        rst = 1'b1;
        step(); rst = 1'b0;
`endif
        m_rack_rdy = '0;
        step(); step();
        chk("end_wq_empty", 64'(wq.size()), 0);
        chk("end_rq_empty", 64'(rq.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // hard stop in case the sequence above stalls
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
